// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants and state encoding for the pipeline debug controller
// Purpose: controller state encoding, UART command bytes, ACK byte, HALT word, dump word counts.
// Ports: none (package).
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_STEP,
    ST_DUMP_LOAD,
    ST_DUMP_SEND,
    ST_DUMP_WAIT,
    ST_ACK
  } dbg_state_t;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HALT  = 8'h48;  // 'H'
  localparam logic [7:0] ACK_BYTE  = 8'h4B;  // 'K'

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int NUM_REGS       = 32;
  localparam int REG_DUMP_WORDS = 1 + NUM_REGS;  // PC followed by R0..R31

endpackage

// File: rtl/dbg_word_serializer.sv
// rtl/dbg_word_serializer.sv - sends one word as MSB-first bytes over the tx handshake
// Purpose: on i_start, latch i_word and emit WIDTH/8 bytes MSB first (or only the MSB
//          byte when i_one_byte), waiting for i_tx_done after each o_tx_start.
// Ports: i_clk, i_reset (async, active-high), i_start, i_one_byte, i_word,
//        o_tx_data, o_tx_start, i_tx_done, o_done (one-cycle pulse after the last byte).
module dbg_word_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_one_byte,
  input  logic [WIDTH-1:0] i_word,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_done,
  output logic             o_done
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {SER_IDLE, SER_SEND, SER_WAIT} ser_state_t;

  ser_state_t       state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] left_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             done_q;

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_done     = done_q;

  // i_tx_done is only honoured in SER_WAIT, i.e. while a byte is outstanding.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= SER_IDLE;
      shift_q    <= '0;
      left_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        SER_IDLE: begin
          if (i_start) begin
            shift_q <= i_word;
            left_q  <= i_one_byte ? '0 : CNT_W'(NBYTES - 1);
            state_q <= SER_SEND;
          end
        end
        SER_SEND: begin
          tx_start_q <= 1'b1;
          tx_data_q  <= shift_q[WIDTH-1 -: 8];
          shift_q    <= shift_q << 8;
          state_q    <= SER_WAIT;
        end
        SER_WAIT: begin
          if (i_tx_done) begin
            if (left_q == '0) begin
              done_q  <= 1'b1;
              state_q <= SER_IDLE;
            end else begin
              left_q  <= left_q - CNT_W'(1);
              state_q <= SER_SEND;
            end
          end
        end
        default: state_q <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// rtl/pipeline_debug_ctrl.sv - UART-driven load/run/step/dump controller for the MIPS pipeline
// Purpose: command FSM, instruction-word assembler and dump sequencer; gates pipeline enable.
// Optional feature macro: DBG_DMEM_DUMP_EN appends DMEM[0..DMEM_DUMP_WORDS-1] to each dump
//   and adds the o_dmem_addr / i_dmem_data ports (and the DMEM parameters).
// Ports: i_clk, i_reset (async, active-high); i_rx_data/i_rx_valid (UART rx);
//        o_tx_data/o_tx_start/i_tx_done (UART tx); o_pipe_en, o_pipe_reset;
//        o_imem_we/o_imem_addr/o_imem_wdata; i_halt_wb, i_pc; o_reg_addr/i_reg_data;
//        o_dmem_addr/i_dmem_data (macro only).
module pipeline_debug_ctrl
  import debug_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int IMEM_ADDR_W = 8
`ifdef DBG_DMEM_DUMP_EN
  ,
  parameter int DMEM_ADDR_W     = 8,
  parameter int DMEM_DUMP_WORDS = 16
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_pipe_en,
  output logic                   o_pipe_reset,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [WIDTH-1:0]       o_imem_wdata,
  input  logic                   i_halt_wb,
  input  logic [WIDTH-1:0]       i_pc,
`ifdef DBG_DMEM_DUMP_EN
  output logic [DMEM_ADDR_W-1:0] o_dmem_addr,
  input  logic [WIDTH-1:0]       i_dmem_data,
`endif
  output logic [4:0]             o_reg_addr,
  input  logic [WIDTH-1:0]       i_reg_data
);

`ifdef DBG_DMEM_DUMP_EN
  localparam int DUMP_WORDS = REG_DUMP_WORDS + DMEM_DUMP_WORDS;
`else
  localparam int DUMP_WORDS = REG_DUMP_WORDS;
`endif
  localparam int IDX_W  = $clog2(DUMP_WORDS + 1);
  localparam int BCNT_W = $clog2(WIDTH / 8);
  localparam logic [IMEM_ADDR_W-1:0] IMEM_LAST = '1;

  dbg_state_t             state_q;
  logic                   halted_q;
  logic [BCNT_W-1:0]      byte_cnt_q;
  logic [IMEM_ADDR_W-1:0] addr_q;
  logic [WIDTH-9:0]       asm_q;       // bytes collected so far; the top byte is never stored
  logic                   imem_we_q;
  logic [IMEM_ADDR_W-1:0] imem_addr_q;
  logic [WIDTH-1:0]       imem_wdata_q;
  logic                   pipe_en_q;
  logic                   pipe_reset_q;
  logic [IDX_W-1:0]       idx_q;       // 0 = PC, 1..32 = R0..R31, then DMEM words
  logic [4:0]             reg_addr_q;
  logic                   ser_start_q;
  logic                   ser_one_q;
  logic [WIDTH-1:0]       ser_word_q;
  logic                   ser_done;
`ifdef DBG_DMEM_DUMP_EN
  logic [DMEM_ADDR_W-1:0] dmem_addr_q;
  assign o_dmem_addr = dmem_addr_q;
`endif

  logic [WIDTH-1:0] asm_next;
  logic [WIDTH-1:0] dump_src;

  assign asm_next = {asm_q, i_rx_data};

  always_comb begin
    dump_src = i_reg_data;
    if (idx_q == '0) begin
      dump_src = i_pc;
`ifdef DBG_DMEM_DUMP_EN
    end else if (idx_q > IDX_W'(NUM_REGS)) begin
      dump_src = i_dmem_data;
`endif
    end
  end

  assign o_pipe_en    = pipe_en_q;
  assign o_pipe_reset = pipe_reset_q;
  assign o_imem_we    = imem_we_q;
  assign o_imem_addr  = imem_addr_q;
  assign o_imem_wdata = imem_wdata_q;
  assign o_reg_addr   = reg_addr_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      halted_q     <= 1'b0;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      asm_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      pipe_en_q    <= 1'b0;
      pipe_reset_q <= 1'b0;
      idx_q        <= '0;
      reg_addr_q   <= '0;
      ser_start_q  <= 1'b0;
      ser_one_q    <= 1'b0;
      ser_word_q   <= '0;
`ifdef DBG_DMEM_DUMP_EN
      dmem_addr_q  <= '0;
`endif
    end else begin
      pipe_reset_q <= 1'b0;
      imem_we_q    <= 1'b0;
      ser_start_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pipe_en_q <= 1'b0;
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: begin
                pipe_reset_q <= 1'b1;
                halted_q     <= 1'b0;
                byte_cnt_q   <= '0;
                addr_q       <= '0;
                state_q      <= ST_LOAD;
              end
              CMD_CONT, CMD_STEP: begin
                // A halted pipeline is never re-enabled; the host just gets a fresh dump.
                if (halted_q) begin
                  idx_q   <= '0;
                  state_q <= ST_DUMP_LOAD;
                end else begin
                  pipe_en_q <= 1'b1;
                  state_q   <= (i_rx_data == CMD_CONT) ? ST_RUN : ST_STEP;
                end
              end
              CMD_RESET: begin
                pipe_reset_q <= 1'b1;
                halted_q     <= 1'b0;
                ser_word_q   <= {ACK_BYTE, (WIDTH-8)'(0)};
                ser_one_q    <= 1'b1;
                ser_start_q  <= 1'b1;
                state_q      <= ST_ACK;
              end
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          if (i_rx_valid) begin
            asm_q      <= asm_next[WIDTH-9:0];
            byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
            if (byte_cnt_q == BCNT_W'(WIDTH / 8 - 1)) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= addr_q;
              imem_wdata_q <= asm_next;
              // Stop on HALT or on the last address; the address counter never wraps.
              if (asm_next == WIDTH'(HALT_WORD) || addr_q == IMEM_LAST) begin
                ser_word_q  <= {ACK_BYTE, (WIDTH-8)'(0)};
                ser_one_q   <= 1'b1;
                ser_start_q <= 1'b1;
                state_q     <= ST_ACK;
              end else begin
                addr_q <= addr_q + IMEM_ADDR_W'(1);
              end
            end
          end
        end
        ST_RUN: begin
          // Halt is checked first so a simultaneous 'H' still records the halt.
          if (i_halt_wb) begin
            halted_q  <= 1'b1;
            pipe_en_q <= 1'b0;
            idx_q     <= '0;
            state_q   <= ST_DUMP_LOAD;
          end else if (i_rx_valid && i_rx_data == CMD_HALT) begin
            pipe_en_q <= 1'b0;
            idx_q     <= '0;
            state_q   <= ST_DUMP_LOAD;
          end
        end
        ST_STEP: begin
          pipe_en_q <= 1'b0;
          if (i_halt_wb) halted_q <= 1'b1;
          idx_q   <= '0;
          state_q <= ST_DUMP_LOAD;
        end
        ST_DUMP_LOAD: begin
          ser_word_q <= dump_src;
          ser_one_q  <= 1'b0;
          state_q    <= ST_DUMP_SEND;
        end
        ST_DUMP_SEND: begin
          ser_start_q <= 1'b1;
          state_q     <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          if (ser_done) begin
            if (idx_q == IDX_W'(DUMP_WORDS - 1)) begin
              state_q <= ST_IDLE;
            end else begin
              // Word idx+1 is R[idx] (or DMEM[idx-32]); set the read address one state ahead.
              idx_q      <= idx_q + IDX_W'(1);
              reg_addr_q <= idx_q[4:0];
`ifdef DBG_DMEM_DUMP_EN
              dmem_addr_q <= DMEM_ADDR_W'(idx_q - IDX_W'(NUM_REGS));
`endif
              state_q    <= ST_DUMP_LOAD;
            end
          end
        end
        ST_ACK: begin
          if (ser_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  dbg_word_serializer #(
    .WIDTH(WIDTH)
  ) u_serializer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (ser_start_q),
    .i_one_byte (ser_one_q),
    .i_word     (ser_word_q),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done),
    .o_done     (ser_done)
  );

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb/tb_pipeline_debug_ctrl.sv - scoreboard bench for pipeline_debug_ctrl
module tb_pipeline_debug_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_pipe_en;
  logic        o_pipe_reset;
  logic        o_imem_we;
  logic [7:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        i_halt_wb;
  logic [31:0] i_pc;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data;
  logic [31:0] regs [0:31];
`ifdef DBG_DMEM_DUMP_EN
  logic [7:0]  o_dmem_addr;
  logic [31:0] i_dmem_data;
  logic [31:0] dmem [0:255];
  localparam int DUMP_BYTES = 196;
  assign i_dmem_data = dmem[o_dmem_addr];
`else
  localparam int DUMP_BYTES = 132;
`endif

  assign i_reg_data = regs[o_reg_addr];

  always #5 clk = ~clk;

  pipeline_debug_ctrl dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .i_tx_done    (i_tx_done),
    .o_pipe_en    (o_pipe_en),
    .o_pipe_reset (o_pipe_reset),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .i_halt_wb    (i_halt_wb),
    .i_pc         (i_pc),
`ifdef DBG_DMEM_DUMP_EN
    .o_dmem_addr  (o_dmem_addr),
    .i_dmem_data  (i_dmem_data),
`endif
    .o_reg_addr   (o_reg_addr),
    .i_reg_data   (i_reg_data)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_tx [$];
  logic [39:0] exp_imem [$];
  logic [39:0] imem_e;
  int tx_seen = 0;
  int en_cnt  = 0;
  int rst_cnt = 0;
  int tx_delay = 3;
  bit outstanding = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a tx byte or an imem write.
  always @(negedge clk) begin
    if (i_reset) begin
      outstanding = 1'b0;
    end else begin
      if (i_tx_done) outstanding = 1'b0;
      if (o_tx_start) begin
        check("tx_start_while_busy", 32'(outstanding), 32'd0);
        outstanding = 1'b1;
        tx_seen++;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: got %h expected none", o_tx_data);
        end else begin
          check("tx_byte", 32'(o_tx_data), 32'(exp_tx.pop_front()));
        end
      end
      if (o_imem_we) begin
        check("imem_we_with_pipe_en", 32'(o_pipe_en), 32'd0);
        if (exp_imem.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_imem_we: got %h@%h expected none", o_imem_wdata, o_imem_addr);
        end else begin
          imem_e = exp_imem.pop_front();
          check("imem_addr", 32'(o_imem_addr), 32'(imem_e[39:32]));
          check("imem_data", o_imem_wdata, imem_e[31:0]);
        end
      end
      if (o_pipe_en) en_cnt++;
      if (o_pipe_reset) rst_cnt++;
    end
  end

  // UART tx model: done arrives tx_delay cycles after each start.
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start && !i_reset) begin
        repeat (tx_delay) @(posedge clk);
        #1 i_tx_done = 1'b1;
        @(posedge clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) exp_tx.push_back(w[k*8 +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] pc);
    push_word(pc);
    for (int r = 0; r < 32; r++) push_word(regs[r]);
`ifdef DBG_DMEM_DUMP_EN
    for (int d = 0; d < 16; d++) push_word(dmem[d]);
`endif
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_imem.size() != 0) && n < 20000) begin
      tick();
      n++;
    end
    check(name, 32'(exp_tx.size() + exp_imem.size()), 32'd0);
    repeat (tx_delay + 10) tick();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_tx_start"}, 32'(o_tx_start), 32'd0);
    check({name, "_tx_data"}, 32'(o_tx_data), 32'd0);
    check({name, "_pipe_en"}, 32'(o_pipe_en), 32'd0);
    check({name, "_pipe_reset"}, 32'(o_pipe_reset), 32'd0);
    check({name, "_imem_we"}, 32'(o_imem_we), 32'd0);
    check({name, "_imem_addr"}, 32'(o_imem_addr), 32'd0);
    check({name, "_imem_wdata"}, o_imem_wdata, 32'd0);
    check({name, "_reg_addr"}, 32'(o_reg_addr), 32'd0);
`ifdef DBG_DMEM_DUMP_EN
    check({name, "_dmem_addr"}, 32'(o_dmem_addr), 32'd0);
`endif
  endtask

  logic [7:0] load_bytes [8];

  initial begin
    i_reset    = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_halt_wb  = 1'b0;
    i_pc       = 32'h0;
    for (int r = 0; r < 32; r++) regs[r] = {8'(r), 8'hA5, 8'(r), 8'h5A};
    regs[0] = 32'h0;
    regs[1] = 32'h5;
`ifdef DBG_DMEM_DUMP_EN
    for (int d = 0; d < 256; d++) dmem[d] = {16'hC0DE, 8'(d), 8'(d)};
    dmem[0] = 32'hDEADBEEF;
`endif
    load_bytes = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    repeat (3) tick();
    check_outputs_zero("reset");
    i_reset = 1'b0;
    repeat (2) tick();

    // Program load: two words, HALT ends the load with an ACK.
    en_cnt = 0; rst_cnt = 0;
    exp_imem.push_back({8'h00, 32'h20010005});
    exp_imem.push_back({8'h01, 32'hFFFFFFFF});
    exp_tx.push_back(8'h4B);
    send_byte(8'h4C);
    check("load_pipe_reset_latency", 32'(o_pipe_reset), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send_byte(load_bytes[i]);
      tick();
    end
    drain("load_drain");
    check("load_pipe_reset_count", 32'(rst_cnt), 32'd1);
    check("load_pipe_en_count", 32'(en_cnt), 32'd0);

    // Single step with PC=4, R1=5.
    i_pc = 32'h4; en_cnt = 0; tx_seen = 0;
    push_dump(32'h4);
    send_byte(8'h53);
    check("step_en_latency", 32'(o_pipe_en), 32'd1);
    tick();
    check("step_en_one_cycle", 32'(o_pipe_en), 32'd0);
    drain("step_drain");
    check("step_en_count", 32'(en_cnt), 32'd1);
    check("step_byte_count", 32'(tx_seen), 32'(DUMP_BYTES));

    // Run until HALT retires in cycle 20.
    i_pc = 32'h8; en_cnt = 0;
    push_dump(32'h8);
    send_byte(8'h43);
    check("run_en_latency", 32'(o_pipe_en), 32'd1);
    repeat (19) tick();
    i_halt_wb = 1'b1;
    tick();
    i_halt_wb = 1'b0;
    check("run_en_after_halt", 32'(o_pipe_en), 32'd0);
    drain("run_drain");
    check("run_en_count", 32'(en_cnt), 32'd20);

    // Step while halted: dump only.
    i_pc = 32'hC; en_cnt = 0;
    push_dump(32'hC);
    send_byte(8'h53);
    drain("halted_step_drain");
    check("halted_step_en_count", 32'(en_cnt), 32'd0);

    // Pipeline reset clears the halted flag.
    rst_cnt = 0;
    exp_tx.push_back(8'h4B);
    send_byte(8'h52);
    check("reset_cmd_pulse", 32'(o_pipe_reset), 32'd1);
    drain("reset_cmd_drain");
    check("reset_cmd_count", 32'(rst_cnt), 32'd1);

    // Abort a run with 'H' at cycle 10.
    i_pc = 32'h10; en_cnt = 0;
    push_dump(32'h10);
    send_byte(8'h43);
    repeat (9) tick();
    send_byte(8'h48);
    check("abort_en_drop", 32'(o_pipe_en), 32'd0);
    drain("abort_drain");
    check("abort_en_count", 32'(en_cnt), 32'd10);

    // Abort does not set halted: a step still enables the pipe once.
    i_pc = 32'h14; en_cnt = 0;
    push_dump(32'h14);
    send_byte(8'h53);
    drain("post_abort_step_drain");
    check("post_abort_step_en_count", 32'(en_cnt), 32'd1);

    // Halt and 'H' together: halt wins.
    i_pc = 32'h18; en_cnt = 0;
    push_dump(32'h18);
    send_byte(8'h43);
    repeat (3) tick();
    i_halt_wb = 1'b1;
    send_byte(8'h48);
    i_halt_wb = 1'b0;
    drain("halt_and_h_drain");
    check("halt_and_h_en_count", 32'(en_cnt), 32'd4);
    i_pc = 32'h1C; en_cnt = 0;
    push_dump(32'h1C);
    send_byte(8'h53);
    drain("halt_wins_step_drain");
    check("halt_wins_en_count", 32'(en_cnt), 32'd0);

    rst_cnt = 0;
    exp_tx.push_back(8'h4B);
    send_byte(8'h52);
    drain("reset_cmd2_drain");
    check("reset_cmd2_count", 32'(rst_cnt), 32'd1);

    // Slow tx link, then reset in the middle of the dump.
    tx_delay = 50; tx_seen = 0; i_pc = 32'h20;
    push_dump(32'h20);
    send_byte(8'h53);
    begin
      int n = 0;
      while (tx_seen < 60 && n < 20000) begin
        tick();
        n++;
      end
    end
    check("bp_reached_byte_60", 32'(tx_seen), 32'd60);
    #2 i_reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    check("bp_bytes_left", 32'(exp_tx.size()), 32'(DUMP_BYTES - 60));
    exp_tx.delete();
    repeat (3) tick();
    i_reset = 1'b0;
    repeat (150) tick();
    check("no_resume_after_reset", 32'(tx_seen), 32'd60);

    // Back in IDLE: a fresh step works normally.
    tx_delay = 3; en_cnt = 0; i_pc = 32'h24;
    push_dump(32'h24);
    send_byte(8'h53);
    check("post_reset_step_en", 32'(o_pipe_en), 32'd1);
    drain("post_reset_drain");
    check("post_reset_en_count", 32'(en_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
